pong_game_ctrl: RTL and testbench
=================================

Name: pong_game_ctrl

Overview:
- Game-state engine directly upstream of the pixel generator.
- Consumes debounced push-buttons and the 4-bit joystick level from the XADC block.
- Produces registered paddle position, ball position, score and state for the pixel generator to draw.
- Runs on the divided pixel clock and advances game physics once per frame, on the falling edge of v_sync.

Parameters:
H_RES, 640, visible width in pixels
V_RES, 480, visible height in pixels
PADDLE_X, 16, paddle left edge x
PADDLE_W, 8, paddle width
PADDLE_H, 64, paddle height
BALL_SIZE, 8, ball side length
DB_CYCLES, 250000, debounce stable-time in clk cycles (10 ms at 25 MHz)
MAX_SPEED, 7, ball speed ceiling in px/frame

Ports:
clk  input  1  pixel clock (divided clock domain); single clock
rst  input  1  synchronous, active-high reset
v_sync  input  1  vertical sync from sync generator, active-low pulse
btn_a  input  1  raw button: serve
btn_b  input  1  raw button: pause toggle
btn_c  input  1  raw button: abort to IDLE
btn_up  input  1  raw button: start / restart
vry  input  4  joystick vertical level 0..15
paddle_y  output  10  paddle top edge y
ball_x  output  10  ball left edge x
ball_y  output  10  ball top edge y
score  output  8  paddle hits, saturating at 255
game_over  output  1  high in OVER state
state  output  2  0 IDLE, 1 SERVE, 2 PLAY, 3 OVER

Behaviour:
- Reset (synchronous, active-high, any state, mid-game included):
  - state=IDLE, paddle_y=208, ball_x=24, ball_y=236, score=0, game_over=0.
  - speed=2, dx=+2, dy=-2, pause=0, hit_cnt=0.
  - Debouncers cleared to 0; v_sync history register set to 1.
- Frame tick:
  - One-cycle internal pulse when the registered v_sync is 1 and the current v_sync is 0.
  - All position updates occur on the clock edge where tick is high, so outputs change one cycle after the falling edge is sampled.
- Debounce, per button:
  - Stable level changes only after the raw input differs from it for DB_CYCLES consecutive cycles; any bounce restarts the count.
  - Press = one-cycle pulse on the stable 0->1 transition.
- Paddle, on every tick in all states:
  - target = vry*26 (0..390).
  - paddle_y moves toward target by min(4, |target-paddle_y|).
  - Never leaves 0..V_RES-PADDLE_H.
- Ball, IDLE/SERVE:
  - On tick, ball_x=PADDLE_X+PADDLE_W, ball_y=(pre-update paddle_y)+28.
- Ball, PLAY with pause=0, on tick, using the pre-update paddle_y:
  - nx=ball_x+dx, ny=ball_y+dy, computed signed 11-bit.
  - ny<=0: ball_y=0, dy=+speed.
  - ny>=V_RES-BALL_SIZE: ball_y=472, dy=-speed.
  - nx>=H_RES-BALL_SIZE: ball_x=632, dx=-speed.
  - Paddle hit: nx<=PADDLE_X+PADDLE_W and ball_y+BALL_SIZE>paddle_y and ball_y<paddle_y+PADDLE_H.
    - ball_x=24, dx=+speed.
    - score+1 (saturating); hit_cnt+1.
    - Every 4th hit, speed+1 up to MAX_SPEED.
  - Else if nx<=PADDLE_X+PADDLE_W: state=OVER, ball frozen.
  - X and Y reflections in the same tick both apply (corner case).
- FSM:
  - IDLE --btn_up press--> SERVE; score=0, speed=2, hit_cnt=0.
  - SERVE --btn_a press--> PLAY; dx=+speed, dy=-speed.
  - PLAY --btn_b press--> toggle pause.
  - PLAY --miss--> OVER; game_over=1.
  - OVER --btn_up press--> IDLE; game_over=0.
  - btn_c press in any state --> IDLE, pause=0. Takes priority over a same-cycle tick or any other press.
- Other simultaneous events:
  - A press and a tick in the same cycle: FSM transition applies first; the tick uses the new state's rules.
  - Presses in states without a listed transition are ignored.
- Registering: all outputs registered; no combinational path from inputs to outputs.

Test Plan:
- Reset: assert rst for 2 cycles mid-PLAY -> next cycle paddle_y=208, ball_x=24, ball_y=236, score=0, state=0, game_over=0.
- Debounce (DB_CYCLES=4):
  - 3-cycle btn_up glitch -> state stays 0.
  - 6-cycle hold -> state=1 exactly once, no repeat while held.
- Paddle slew: vry=15 from reset, 46 frame ticks -> paddle_y=388 after tick 45, 390 after tick 46, then stable.
- Serve/top bounce: serve with paddle_y=208 (ball_y=236) -> after 118 ticks ball_y=0 and dy=+2; after tick 119 ball_y=2.
- Paddle hit: place paddle over the returning ball -> score 0->1, dx=+2, ball_x=24. After the 4th hit speed=3.
- Miss and restart: ball returns with paddle at 0 and ball_y=300 -> state=3, game_over=1. btn_up press -> state=0. Simultaneous btn_c press and tick in PLAY -> state=0, ball not advanced.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// Pong game-state engine: debounces the buttons, runs the IDLE/SERVE/PLAY/OVER
// FSM and advances paddle and ball physics once per frame on the v_sync falling edge.
module pong_game_ctrl #(
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  parameter int PADDLE_X  = 16,
  parameter int PADDLE_W  = 8,
  parameter int PADDLE_H  = 64,
  parameter int BALL_SIZE = 8,
  parameter int DB_CYCLES = 250000,
  parameter int MAX_SPEED = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       v_sync,
  input  logic       btn_a,
  input  logic       btn_b,
  input  logic       btn_c,
  input  logic       btn_up,
  input  logic [3:0] vry,
  output logic [9:0] paddle_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [7:0] score,
  output logic       game_over,
  output logic [1:0] state
);

  typedef enum logic [1:0] {S_IDLE, S_SERVE, S_PLAY, S_OVER} state_t;

  localparam int              CW         = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0]   DB_LAST    = CW'(DB_CYCLES - 1);
  localparam logic [9:0]      X_HOME     = 10'(PADDLE_X + PADDLE_W);
  localparam logic [9:0]      X_WALL     = 10'(H_RES - BALL_SIZE);
  localparam logic [9:0]      Y_WALL     = 10'(V_RES - BALL_SIZE);
  localparam logic [9:0]      PY_RST     = 10'((V_RES - PADDLE_H) / 2);
  localparam logic [9:0]      BALL_Y_OFF = 10'((PADDLE_H - BALL_SIZE) / 2);
  localparam logic signed [10:0] SX_HOME = 11'(PADDLE_X + PADDLE_W);
  localparam logic signed [10:0] SX_WALL = 11'(H_RES - BALL_SIZE);
  localparam logic signed [10:0] SY_WALL = 11'(V_RES - BALL_SIZE);

  // Button index: 0 serve, 1 pause, 2 abort, 3 start/restart
  logic [3:0]    raw, stable, press;
  logic [CW-1:0] db_cnt [4];
  logic          vs_q, tick;

  state_t             state_q, state_n;
  logic               pause, pause_n;
  logic [2:0]         speed, speed_n;
  logic signed [3:0]  dx, dx_n, dy, dy_n;
  logic [7:0]         hit_cnt, hit_n, score_n;
  logic [9:0]         py_n, bx_n, by_n, target, step;
  logic signed [10:0] nx, ny;
  logic [10:0]        by_w, py_w;
  logic               miss;

  assign raw   = {btn_up, btn_c, btn_b, btn_a};
  assign tick  = vs_q & ~v_sync;
  assign state = state_q;

  always_comb begin
    press = '0;
    for (int i = 0; i < 4; i++)
      press[i] = raw[i] & ~stable[i] & (db_cnt[i] == DB_LAST);
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned (which would infer a latch); blocking '=' is right here because
  // later statements read values computed earlier in the same pass.
  always_comb begin
    state_n = state_q;
    pause_n = pause;
    speed_n = speed;
    dx_n    = dx;
    dy_n    = dy;
    hit_n   = hit_cnt;
    score_n = score;
    py_n    = paddle_y;
    bx_n    = ball_x;
    by_n    = ball_y;
    nx      = '0;
    ny      = '0;
    step    = '0;
    miss    = 1'b0;
    by_w    = {1'b0, ball_y};
    py_w    = {1'b0, paddle_y};
    target  = 10'(vry) * 10'd26;

    // FSM transitions resolve first; a same-cycle tick then follows the new state.
    if (press[2]) begin
      state_n = S_IDLE;
      pause_n = 1'b0;
    end else begin
      case (state_q)
        S_IDLE:  if (press[3]) begin
                   state_n = S_SERVE;
                   score_n = '0;
                   speed_n = 3'd2;
                   hit_n   = '0;
                 end
        S_SERVE: if (press[0]) begin
                   state_n = S_PLAY;
                   dx_n    = $signed({1'b0, speed});
                   dy_n    = -$signed({1'b0, speed});
                 end
        S_PLAY:  if (press[1]) pause_n = ~pause;
        S_OVER:  if (press[3]) state_n = S_IDLE;
        default: ;
      endcase
    end

    // An abort swallows the frame tick entirely.
    if (tick && !press[2]) begin
      // target never exceeds 390, so the paddle stays inside the field.
      if (target > paddle_y) begin
        step = (target - paddle_y > 10'd4) ? 10'd4 : target - paddle_y;
        py_n = paddle_y + step;
      end else begin
        step = (paddle_y - target > 10'd4) ? 10'd4 : paddle_y - target;
        py_n = paddle_y - step;
      end

      case (state_n)
        S_IDLE, S_SERVE: begin
          bx_n = X_HOME;
          by_n = paddle_y + BALL_Y_OFF;
        end
        S_PLAY: if (!pause_n) begin
          nx = $signed({1'b0, ball_x}) + $signed({{7{dx_n[3]}}, dx_n});
          ny = $signed({1'b0, ball_y}) + $signed({{7{dy_n[3]}}, dy_n});
          if (nx <= SX_HOME) begin
            if ((by_w + 11'(BALL_SIZE) > py_w) && (by_w < py_w + 11'(PADDLE_H))) begin
              bx_n    = X_HOME;
              dx_n    = $signed({1'b0, speed});
              score_n = (score == 8'hFF) ? score : score + 8'd1;
              hit_n   = hit_cnt + 8'd1;
              if (hit_n[1:0] == 2'b00 && speed < 3'(MAX_SPEED)) speed_n = speed + 3'd1;
            end else begin
              state_n = S_OVER;
              miss    = 1'b1;
            end
          end else if (nx >= SX_WALL) begin
            bx_n = X_WALL;
            dx_n = -$signed({1'b0, speed});
          end else begin
            bx_n = nx[9:0];
          end
          if (!miss) begin
            if (ny <= 11'sd0) begin
              by_n = '0;
              dy_n = $signed({1'b0, speed});
            end else if (ny >= SY_WALL) begin
              by_n = Y_WALL;
              dy_n = -$signed({1'b0, speed});
            end else begin
              by_n = ny[9:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q      <= 1'b1;
      stable    <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
      state_q   <= S_IDLE;
      paddle_y  <= PY_RST;
      ball_x    <= X_HOME;
      ball_y    <= PY_RST + BALL_Y_OFF;
      score     <= '0;
      game_over <= 1'b0;
      speed     <= 3'd2;
      dx        <= 4'sd2;
      dy        <= -4'sd2;
      pause     <= 1'b0;
      hit_cnt   <= '0;
    end else begin
      vs_q <= v_sync;
      for (int i = 0; i < 4; i++) begin
        if (raw[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= raw[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CW'(1);
        end
      end
      state_q   <= state_n;
      paddle_y  <= py_n;
      ball_x    <= bx_n;
      ball_y    <= by_n;
      score     <= score_n;
      game_over <= (state_n == S_OVER);
      speed     <= speed_n;
      dx        <= dx_n;
      dy        <= dy_n;
      pause     <= pause_n;
      hit_cnt   <= hit_n;
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: slew table, hand-placed corner sequences and a
// behavioural ball/paddle model feeding a scoreboard of expected outputs.
module tb_pong_game_ctrl;
  logic       clk = 1'b0;
  logic       rst, v_sync, btn_a, btn_b, btn_c, btn_up;
  logic [3:0] vry;
  logic [9:0] paddle_y, ball_x, ball_y;
  logic [7:0] score;
  logic       game_over;
  logic [1:0] state;

  pong_game_ctrl #(.DB_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .v_sync(v_sync), .btn_a(btn_a), .btn_b(btn_b),
    .btn_c(btn_c), .btn_up(btn_up), .vry(vry), .paddle_y(paddle_y),
    .ball_x(ball_x), .ball_y(ball_y), .score(score), .game_over(game_over),
    .state(state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { string name; int sel; int val; } exp_t;
  exp_t sb[$];

  typedef struct { int vry; int ticks; int py; int by; } vec_t;
  vec_t tbl[10];

  int m_py, m_bx, m_by, m_dx, m_dy, m_speed, m_hits, m_score, m_st;
  bit m_pause;

  function automatic int dut_field(int sel);
    int r;
    case (sel)
      0: r = int'(paddle_y);
      1: r = int'(ball_x);
      2: r = int'(ball_y);
      3: r = int'(score);
      4: r = int'(state);
      5: r = int'(game_over);
      default: r = -1;
    endcase
    return r;
  endfunction

  task automatic push(string n, int sel, int v);
    exp_t e;
    e.name = n; e.sel = sel; e.val = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    int act;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      act = dut_field(e.sel);
      n_cmp++;
      if (act != e.val) begin
        n_bad++;
        $display("FAIL %s: got %0d, expected %0d (t=%0t)", e.name, act, e.val, $time);
      end
    end
  endtask

  task automatic fail_now(string n);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event bound expired", n);
  endtask

  task automatic model_reset();
    m_py = 208; m_bx = 24; m_by = 236; m_dx = 2; m_dy = -2;
    m_speed = 2; m_hits = 0; m_score = 0; m_st = 0; m_pause = 0;
  endtask

  task automatic model_tick();
    int opy, tgt, nx, ny, spd;
    bit miss;
    opy = m_py; tgt = int'(vry) * 26; spd = m_speed; miss = 0;
    if (tgt > m_py) m_py += (tgt - m_py > 4) ? 4 : tgt - m_py;
    else            m_py -= (m_py - tgt > 4) ? 4 : m_py - tgt;
    if (m_st < 2) begin
      m_bx = 24; m_by = opy + 28;
    end else if (m_st == 2 && !m_pause) begin
      nx = m_bx + m_dx; ny = m_by + m_dy;
      if (nx <= 24) begin
        if (m_by + 8 > opy && m_by < opy + 64) begin
          m_bx = 24; m_dx = spd;
          if (m_score < 255) m_score++;
          m_hits++;
          if (m_hits % 4 == 0 && m_speed < 7) m_speed++;
        end else begin
          m_st = 3; miss = 1;
        end
      end else if (nx >= 632) begin
        m_bx = 632; m_dx = -spd;
      end else begin
        m_bx = nx;
      end
      if (!miss) begin
        if (ny <= 0)        begin m_by = 0;   m_dy = spd;  end
        else if (ny >= 472) begin m_by = 472; m_dy = -spd; end
        else                m_by = ny;
      end
    end
  endtask

  // One frame: v_sync low for a single cycle, then sample on the following negedge.
  task automatic tick_frame();
    @(negedge clk) v_sync = 1'b0;
    @(negedge clk) v_sync = 1'b1;
    model_tick();
    push("tick_py", 0, m_py);
    push("tick_bx", 1, m_bx);
    push("tick_by", 2, m_by);
    push("tick_score", 3, m_score);
    push("tick_state", 4, m_st);
    push("tick_over", 5, (m_st == 3) ? 1 : 0);
    drain();
  endtask

  task automatic set_btn(int idx, logic v);
    case (idx)
      0: btn_a  = v;
      1: btn_b  = v;
      2: btn_c  = v;
      default: btn_up = v;
    endcase
  endtask

  task automatic press_btn(int idx);
    @(negedge clk) set_btn(idx, 1'b1);
    repeat (5) @(negedge clk);
    set_btn(idx, 1'b0);
    repeat (6) @(negedge clk);
  endtask

  task automatic enter_serve();
    press_btn(3);
    m_st = 1; m_score = 0; m_speed = 2; m_hits = 0;
  endtask

  task automatic enter_play();
    press_btn(0);
    m_st = 2; m_dx = m_speed; m_dy = -m_speed;
  endtask

  task automatic track_ball();
    int v;
    v = (m_by - 15) / 26;
    if (v < 0) v = 0;
    if (v > 15) v = 15;
    vry = 4'(v);
  endtask

  task automatic check_reset(string tag);
    push({tag, "_py"}, 0, 208);
    push({tag, "_bx"}, 1, 24);
    push({tag, "_by"}, 2, 236);
    push({tag, "_score"}, 3, 0);
    push({tag, "_state"}, 4, 0);
    push({tag, "_over"}, 5, 0);
    drain();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int sx, sy, seen, prev, t;

    tbl[0] = '{15, 45, 388, 412};
    tbl[1] = '{15,  1, 390, 416};
    tbl[2] = '{15,  3, 390, 418};
    tbl[3] = '{ 0,  1, 386, 418};
    tbl[4] = '{ 0, 96,   2,  34};
    tbl[5] = '{ 0,  1,   0,  30};
    tbl[6] = '{ 0,  2,   0,  28};
    tbl[7] = '{ 8,  1,   4,  28};
    tbl[8] = '{ 8, 50, 204, 228};
    tbl[9] = '{ 8,  1, 208, 232};

    rst = 1'b1; v_sync = 1'b1; btn_a = 0; btn_b = 0; btn_c = 0; btn_up = 0; vry = 4'd8;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset("rst0");
    rst = 1'b0;

    // Short glitch must not register as a press.
    @(negedge clk) btn_up = 1'b1;
    repeat (3) @(negedge clk);
    btn_up = 1'b0;
    repeat (6) @(negedge clk);
    push("glitch_state", 4, 0);
    drain();

    // Paddle slew table, ball follows the pre-update paddle in IDLE.
    for (int i = 0; i < 10; i++) begin
      vry = 4'(tbl[i].vry);
      repeat (tbl[i].ticks) tick_frame();
      push($sformatf("slew%0d_py", i), 0, tbl[i].py);
      push($sformatf("slew%0d_by", i), 2, tbl[i].by);
      drain();
    end

    // Long hold: exactly one press at the 4th high cycle, none afterwards.
    @(negedge clk) btn_up = 1'b1;
    repeat (3) @(negedge clk);
    push("hold_pre", 4, 0);
    drain();
    @(negedge clk);
    push("hold_press", 4, 1);
    drain();
    m_st = 1; m_score = 0; m_speed = 2; m_hits = 0;
    repeat (2) @(negedge clk);
    push("hold_held", 4, 1);
    drain();
    btn_up = 1'b0;
    repeat (6) @(negedge clk);
    push("hold_release", 4, 1);
    drain();

    tick_frame();
    push("serve_bx", 1, 24);
    push("serve_by", 2, 236);
    drain();

    enter_play();
    push("play_state", 4, 2);
    drain();
    repeat (118) tick_frame();
    push("top_by", 2, 0);
    push("top_bx", 1, 260);
    drain();
    tick_frame();
    push("bounce_by", 2, 2);
    push("bounce_bx", 1, 262);
    drain();

    // Pause freezes the ball; second toggle resumes it.
    press_btn(1);
    m_pause = 1;
    tick_frame();
    push("pause_bx", 1, 262);
    push("pause_by", 2, 2);
    drain();
    press_btn(1);
    m_pause = 0;
    tick_frame();
    push("resume_bx", 1, 264);
    push("resume_by", 2, 4);
    drain();

    // Rally with the paddle tracking the ball until four hits.
    seen = 0;
    t = 0;
    while (t < 5000 && seen < 4) begin
      track_ball();
      prev = m_hits;
      tick_frame();
      if (m_hits != prev) begin
        seen++;
        push("hit_score", 3, seen);
        push("hit_bx", 1, 24);
        push("hit_state", 4, 2);
        drain();
        if (seen == 1) begin
          tick_frame();
          push("hit1_dx", 1, 26);
          drain();
        end
      end
      t++;
    end
    if (seen < 4) fail_now("rally_timeout");

    // After the 4th hit the next wall reflection uses speed 3.
    t = 0;
    while (t < 1000 && m_bx != 632) begin
      track_ball();
      tick_frame();
      t++;
    end
    if (m_bx != 632) fail_now("wall_timeout");
    else begin
      track_ball();
      tick_frame();
      push("speed3_bx", 1, 629);
      drain();
    end

    // Steer the paddle away from the ball until it is missed.
    t = 0;
    while (t < 5000 && m_st != 3) begin
      vry = (m_by < 200) ? 4'd15 : 4'd0;
      tick_frame();
      t++;
    end
    if (m_st != 3) fail_now("miss_timeout");
    else begin
      push("miss_state", 4, 3);
      push("miss_over", 5, 1);
      drain();
      sx = m_bx; sy = m_by;
      tick_frame();
      push("frozen_bx", 1, sx);
      push("frozen_by", 2, sy);
      drain();
    end

    press_btn(3);
    m_st = 0;
    push("restart_state", 4, 0);
    push("restart_over", 5, 0);
    drain();
    vry = 4'd8;
    tick_frame();

    enter_serve();
    push("reserve_score", 3, 0);
    push("reserve_state", 4, 1);
    drain();
    tick_frame();
    enter_play();
    repeat (3) tick_frame();

    // Abort coinciding with a frame tick: back to IDLE, ball untouched.
    sx = m_bx; sy = m_by;
    @(negedge clk) btn_c = 1'b1;
    repeat (2) @(negedge clk);
    @(negedge clk) v_sync = 1'b0;
    @(negedge clk) v_sync = 1'b1;
    m_st = 0; m_pause = 0;
    push("abort_state", 4, 0);
    push("abort_bx", 1, sx);
    push("abort_by", 2, sy);
    drain();
    btn_c = 1'b0;
    repeat (6) @(negedge clk);
    tick_frame();

    // Reset in the middle of play.
    enter_serve();
    tick_frame();
    enter_play();
    vry = 4'd3;
    repeat (5) tick_frame();
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    check_reset("rst_mid");
    model_reset();
    tick_frame();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
